// File: rtl/obstacle_gen.sv
`default_nettype none
// ============================================================================
// Module      : obstacle_gen
// Description : Obstacle field producer for the game-logic stage. Owns ten
//               obstacle slots. Spawns obstacles at the right screen edge on
//               a fixed cadence, with size and ceiling/floor attachment taken
//               from a 16-bit LFSR. Scrolls active obstacles left while the
//               game runs, retires the ones that leave the screen, and counts
//               retirements as the score.
// Ports       : clk        - clock, rising edge
//               rst_n      - asynchronous active-low reset
//               gamemode   - 00 initial, 01 running, 10 paused, 11 ended
//               obstacle_x - slot k: [k*20 +:10] x_left, [k*20+10 +:10] x_right
//               obstacle_y - slot k: [k*18 +:9] y_top,   [k*18+9 +:9]   y_bottom
//               score      - retired obstacle count, saturating at 16'hFFFF
// Revision    : 1.0 - initial release
// ============================================================================
module obstacle_gen #(
  parameter int          SCREEN_W       = 640,
  parameter int          OBS_W          = 40,
  parameter int          SPEED          = 4,
  parameter int          SPAWN_INTERVAL = 60,
  parameter int          UPPER_BOUND    = 120,
  parameter int          LOWER_BOUND    = 360,
  parameter int          MIN_H          = 40,
  parameter int          MAX_H          = 120,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   gamemode,
  output logic [199:0] obstacle_x,
  output logic [179:0] obstacle_y,
  output logic [15:0]  score
);

  localparam int c_nslots = 10;
  localparam int c_cnt_w  = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;

  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SPAWN_INTERVAL - 1);
  localparam logic [9:0]         c_speed    = 10'(SPEED);
  localparam logic [9:0]         c_spawn_xl = 10'(SCREEN_W);
  localparam logic [9:0]         c_spawn_xr = 10'(SCREEN_W + OBS_W - 1);
  localparam logic [8:0]         c_upper    = 9'(UPPER_BOUND);
  localparam logic [8:0]         c_lower    = 9'(LOWER_BOUND);
  localparam logic [8:0]         c_min_h    = 9'(MIN_H);
  localparam logic [8:0]         c_h_range  = 9'(MAX_H - MIN_H + 1);

  localparam logic [1:0] c_mode_init    = 2'b00;
  localparam logic [1:0] c_mode_running = 2'b01;

  // Slot registers
  logic [9:0]         r_xl [c_nslots];
  logic [9:0]         r_xr [c_nslots];
  logic [8:0]         r_yt [c_nslots];
  logic [8:0]         r_yb [c_nslots];
  logic [15:0]        r_lfsr;
  logic [c_cnt_w-1:0] r_cnt;
  logic [15:0]        r_score;

  logic [c_nslots-1:0] w_active;
  logic [c_nslots-1:0] w_retire;
  logic [c_nslots-1:0] w_spawn_sel;
  logic                w_found;
  logic [3:0]          w_ret_cnt;
  logic [16:0]         w_score_sum;
  logic                w_spawn_now;
  logic                w_lfsr_fb;
  logic [8:0]          w_h;
  logic [8:0]          w_yt_new;
  logic [8:0]          w_yb_new;

  always_comb begin
    w_active    = '0;
    w_retire    = '0;
    w_spawn_sel = '0;
    w_found     = 1'b0;
    w_ret_cnt   = '0;

    w_lfsr_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    w_h         = c_min_h + ({2'b00, r_lfsr[6:0]} % c_h_range);
    if (r_lfsr[15]) begin
      w_yt_new = c_lower - w_h;
      w_yb_new = c_lower;
    end else begin
      w_yt_new = c_upper;
      w_yb_new = c_upper + w_h;
    end

    w_spawn_now = (r_cnt == c_cnt_last);

    // Eligibility is judged on the state at the start of the cycle, so a
    // slot retiring now is still "active" here and cannot take the spawn.
    for (int k = 0; k < c_nslots; k++) begin
      w_active[k] = (r_xl[k] != '0) || (r_xr[k] != '0) ||
                    (r_yt[k] != '0) || (r_yb[k] != '0);
      w_retire[k] = w_active[k] && (r_xr[k] < c_speed);
      if (!w_active[k] && !w_found) begin
        w_spawn_sel[k] = 1'b1;
        w_found        = 1'b1;
      end
      w_ret_cnt = w_ret_cnt + {3'b000, w_retire[k]};
    end

    w_score_sum = {1'b0, r_score} + {13'd0, w_ret_cnt};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr  <= LFSR_SEED;
      r_cnt   <= '0;
      r_score <= '0;
      for (int k = 0; k < c_nslots; k++) begin
        r_xl[k] <= '0;
        r_xr[k] <= '0;
        r_yt[k] <= '0;
        r_yb[k] <= '0;
      end
    end else begin
      // The LFSR free-runs in every mode.
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};

      if (gamemode == c_mode_init) begin
        r_cnt   <= '0;
        r_score <= '0;
        for (int k = 0; k < c_nslots; k++) begin
          r_xl[k] <= '0;
          r_xr[k] <= '0;
          r_yt[k] <= '0;
          r_yb[k] <= '0;
        end
      end else if (gamemode == c_mode_running) begin
        r_cnt   <= w_spawn_now ? '0 : r_cnt + 1'b1;
        r_score <= w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
        for (int k = 0; k < c_nslots; k++) begin
          if (w_spawn_now && w_spawn_sel[k]) begin
            r_xl[k] <= c_spawn_xl;
            r_xr[k] <= c_spawn_xr;
            r_yt[k] <= w_yt_new;
            r_yb[k] <= w_yb_new;
          end else if (w_retire[k]) begin
            r_xl[k] <= '0;
            r_xr[k] <= '0;
            r_yt[k] <= '0;
            r_yb[k] <= '0;
          end else if (w_active[k]) begin
            // Left edge clamps at the screen border; right edge keeps
            // moving until it drops below SPEED and the slot retires.
            r_xl[k] <= (r_xl[k] > c_speed) ? (r_xl[k] - c_speed) : '0;
            r_xr[k] <= r_xr[k] - c_speed;
          end
        end
      end
      // Paused and ended: everything except the LFSR holds.
    end
  end

  generate
    for (genvar g = 0; g < c_nslots; g++) begin : g_pack
      assign obstacle_x[g*20 +: 10]    = r_xl[g];
      assign obstacle_x[g*20+10 +: 10] = r_xr[g];
      assign obstacle_y[g*18 +: 9]     = r_yt[g];
      assign obstacle_y[g*18+9 +: 9]   = r_yb[g];
    end
  endgenerate

  assign score = r_score;

endmodule
`default_nettype wire

// File: tb/tb_obstacle_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_obstacle_gen
// Description : Self-checking bench for obstacle_gen. Instance A uses the
//               default parameters; instance B uses SPAWN_INTERVAL=2,
//               SPEED=1 to fill every slot. Expected values are queued with
//               the edge after which they must hold; a negedge monitor pops
//               and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_obstacle_gen;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   gm_a, gm_b;
  logic [199:0] ox_a, ox_b;
  logic [179:0] oy_a, oy_b;
  logic [15:0]  sc_a, sc_b;

  always #5 clk = ~clk;

  obstacle_gen dut_a (
    .clk(clk), .rst_n(rst_n), .gamemode(gm_a),
    .obstacle_x(ox_a), .obstacle_y(oy_a), .score(sc_a)
  );

  obstacle_gen #(.SPAWN_INTERVAL(2), .SPEED(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .gamemode(gm_b),
    .obstacle_x(ox_b), .obstacle_y(oy_b), .score(sc_b)
  );

  typedef struct {
    int    e;
    int    dut;
    int    sel;   // 0 xl, 1 xr, 2 yt, 3 yb, 4 score, 5 slot-is-free
    int    slot;
    int    val;
    string name;
  } exp_t;

  exp_t q[$];
  int   edge_n = 0;
  int   checks = 0;
  int   errors = 0;
  bit   geo_on = 1'b0;

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic int field(input int dut, input int sel, input int k);
    logic [199:0] x;
    logic [179:0] y;
    logic [15:0]  s;
    x = (dut == 0) ? ox_a : ox_b;
    y = (dut == 0) ? oy_a : oy_b;
    s = (dut == 0) ? sc_a : sc_b;
    case (sel)
      0:       return int'(x[k*20 +: 10]);
      1:       return int'(x[k*20+10 +: 10]);
      2:       return int'(y[k*18 +: 9]);
      3:       return int'(y[k*18+9 +: 9]);
      4:       return int'(s);
      default: return ((x[k*20 +: 20] == '0) && (y[k*18 +: 18] == '0)) ? 1 : 0;
    endcase
  endfunction

  function automatic logic [15:0] lfsr_at(input int n);
    logic [15:0] l;
    l = 16'hACE1;
    for (int i = 0; i < n; i++) l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    return l;
  endfunction

  // Monitor
  always @(negedge clk) begin
    int act, xl, xr, yt, yb;
    bit ok;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].e == edge_n) begin
        act = field(q[i].dut, q[i].sel, q[i].slot);
        checks++;
        if (act != q[i].val) begin
          errors++;
          $display("FAIL %s: slot %0d got %0d, expected %0d (edge %0d)",
                   q[i].name, q[i].slot, act, q[i].val, edge_n);
        end
        q.delete(i);
      end
    end
    if (geo_on) begin
      for (int k = 0; k < 10; k++) begin
        if (field(0, 5, k) == 0) begin
          xl = field(0, 0, k); xr = field(0, 1, k);
          yt = field(0, 2, k); yb = field(0, 3, k);
          ok = ((yt == 120 && yb >= 160 && yb <= 240) ||
                (yb == 360 && yt >= 240 && yt <= 320)) &&
               (xr - xl <= 39) && (yt != yb);
          checks++;
          if (!ok) begin
            errors++;
            $display("FAIL geometry: slot %0d got x=%0d..%0d y=%0d..%0d, expected legal shape (edge %0d)",
                     k, xl, xr, yt, yb, edge_n);
          end
        end
      end
    end
  end

  task automatic run(input logic [1:0] ma, input logic [1:0] mb, input int n);
    gm_a = ma;
    gm_b = mb;
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_v(input int e, input int dut, input int sel, input int k,
                          input int val, input string nm);
    exp_t it;
    it.e = e; it.dut = dut; it.sel = sel; it.slot = k; it.val = val; it.name = nm;
    q.push_back(it);
  endtask

  task automatic expect_zero(input int e, input int dut, input int k, input string nm);
    expect_v(e, dut, 5, k, 1, nm);
  endtask

  // Spawn into slot k of instance A using the LFSR after 'steps' advances.
  task automatic expect_spawn(input int e, input int k, input int steps, input string nm);
    logic [15:0] l;
    int h, yt, yb;
    l = lfsr_at(steps);
    h = 40 + (int'(l[6:0]) % 81);
    if (l[15]) begin
      yt = 360 - h; yb = 360;
    end else begin
      yt = 120; yb = 120 + h;
    end
    expect_v(e, 0, 0, k, 640, {nm, "_xl"});
    expect_v(e, 0, 1, k, 679, {nm, "_xr"});
    expect_v(e, 0, 2, k, yt,  {nm, "_yt"});
    expect_v(e, 0, 3, k, yb,  {nm, "_yb"});
  endtask

  initial begin
    int t, r, s0, p, q0, r2, b0;
    rst_n = 1'b0;
    gm_a  = 2'b00;
    gm_b  = 2'b00;
    @(negedge clk);

    // Reset state
    t = edge_n;
    for (int k = 0; k < 10; k++) expect_zero(t + 2, 0, k, "reset_zero");
    expect_v(t + 2, 0, 4, 0, 0, "reset_score");
    run(2'b00, 2'b00, 2);

    // Initial mode holds everything at zero
    rst_n = 1'b1;
    r = edge_n;
    for (int k = 0; k < 10; k++) begin
      expect_zero(r + 50, 0, k, "init_hold_zero");
      expect_zero(r + 100, 0, k, "init_hold_zero");
    end
    run(2'b00, 2'b00, 100);

    // First spawn on the 60th running edge, then scrolling
    s0 = edge_n;
    expect_zero(s0 + 59, 0, 0, "pre_spawn_slot0");
    expect_spawn(s0 + 60, 0, s0 + 60 - r - 1, "first_spawn");
    for (int k = 1; k < 10; k++) expect_zero(s0 + 60, 0, k, "first_spawn_others");
    expect_v(s0 + 61, 0, 0, 0, 636, "scroll_xl");
    expect_v(s0 + 61, 0, 1, 0, 675, "scroll_xr");
    expect_v(s0 + 100, 0, 0, 0, 480, "pre_pause_xl");
    expect_zero(s0 + 100, 0, 1, "pre_pause_slot1");
    run(2'b01, 2'b00, 100);

    // Pause freezes
    expect_v(s0 + 125, 0, 0, 0, 480, "paused_xl");
    expect_v(s0 + 150, 0, 0, 0, 480, "paused_xl_end");
    expect_v(s0 + 150, 0, 4, 0, 0, "paused_score");
    expect_zero(s0 + 150, 0, 1, "paused_no_spawn");
    run(2'b10, 2'b00, 50);

    // Resume: counter continues, next spawn 20 running edges later
    p = edge_n;
    expect_zero(p + 19, 0, 1, "resume_pre_spawn");
    expect_v(p + 19, 0, 0, 0, 404, "resume_slot0_xl");
    expect_spawn(p + 20, 1, p + 20 - r - 1, "resume_spawn");
    expect_v(p + 20, 0, 0, 0, 400, "resume_slot0_xl2");
    expect_spawn(p + 80, 2, p + 80 - r - 1, "third_spawn");
    expect_v(p + 129, 0, 1, 0, 3, "pre_retire_xr");
    expect_v(p + 129, 0, 0, 0, 0, "pre_retire_xl_clamp");
    expect_v(p + 129, 0, 4, 0, 0, "pre_retire_score");
    expect_zero(p + 130, 0, 0, "retire_slot0");
    expect_v(p + 130, 0, 4, 0, 1, "retire_score");
    expect_zero(p + 139, 0, 0, "slot0_stays_free");
    expect_spawn(p + 140, 0, p + 140 - r - 1, "reuse_slot0");
    expect_v(p + 140, 0, 4, 0, 1, "reuse_score");
    run(2'b01, 2'b00, 140);

    // Ended freezes
    expect_v(p + 170, 0, 0, 0, 640, "ended_slot0_xl");
    expect_v(p + 170, 0, 0, 1, 160, "ended_slot1_xl");
    expect_v(p + 170, 0, 4, 0, 1, "ended_score");
    run(2'b11, 2'b00, 30);

    // Back to initial clears on the first edge
    q0 = edge_n;
    for (int k = 0; k < 10; k++) expect_zero(q0 + 1, 0, k, "init_clear");
    expect_v(q0 + 1, 0, 4, 0, 0, "init_clear_score");
    run(2'b00, 2'b00, 1);

    q0 = edge_n;
    expect_spawn(q0 + 60, 0, q0 + 60 - r - 1, "rerun_spawn");
    run(2'b01, 2'b00, 80);

    // Reset mid-run; LFSR and counter restart
    rst_n = 1'b0;
    t = edge_n;
    for (int k = 0; k < 10; k++) expect_zero(t + 2, 0, k, "midrun_reset_zero");
    expect_v(t + 2, 0, 4, 0, 0, "midrun_reset_score");
    run(2'b01, 2'b00, 2);
    rst_n = 1'b1;
    r2 = edge_n;
    expect_zero(r2 + 59, 0, 0, "seed_pre_spawn");
    expect_spawn(r2 + 60, 0, 59, "seed_spawn");
    for (int k = 1; k < 10; k++) expect_zero(r2 + 60, 0, k, "seed_spawn_others");
    run(2'b01, 2'b00, 60);

    // Long run with geometry invariants
    geo_on = 1'b1;
    run(2'b01, 2'b00, 10000);
    geo_on = 1'b0;

    // Full-slot behaviour on instance B
    run(2'b00, 2'b00, 1);
    b0 = edge_n;
    expect_zero(b0 + 1, 1, 0, "b_pre_spawn");
    expect_v(b0 + 2, 1, 0, 0, 640, "b_first_spawn");
    expect_v(b0 + 20, 1, 0, 9, 640, "b_slot9_spawn");
    expect_v(b0 + 20, 1, 0, 0, 622, "b_slot0_xl");
    expect_v(b0 + 22, 1, 0, 0, 620, "b_drop_slot0_xl");
    expect_v(b0 + 22, 1, 1, 0, 659, "b_drop_slot0_xr");
    expect_v(b0 + 22, 1, 0, 9, 638, "b_drop_slot9_xl");
    expect_v(b0 + 681, 1, 1, 0, 0, "b_pre_retire_xr");
    expect_v(b0 + 681, 1, 5, 0, 0, "b_pre_retire_active");
    expect_zero(b0 + 682, 1, 0, "b_retire_slot0");
    expect_v(b0 + 682, 1, 4, 0, 1, "b_retire_score");
    expect_zero(b0 + 683, 1, 0, "b_no_refill_odd");
    expect_v(b0 + 684, 1, 0, 0, 640, "b_refill_slot0");
    expect_zero(b0 + 684, 1, 1, "b_slot1_retired");
    expect_v(b0 + 684, 1, 4, 0, 2, "b_refill_score");
    run(2'b00, 2'b01, 690);

    run(2'b00, 2'b00, 2);
    foreach (q[i]) begin
      errors++;
      $display("FAIL unchecked %s: slot %0d never compared, expected %0d at edge %0d",
               q[i].name, q[i].slot, q[i].val, q[i].e);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/obstacle_gen.md
# obstacle_gen

Upstream producer of the obstacle field consumed by the game-logic stage. It owns 10 obstacle slots and spawns new obstacles at the right screen edge on a fixed cadence, using an LFSR to pick each obstacle's size and whether it hangs from the ceiling or rises from the floor. It scrolls every active obstacle left each cycle while the game is running, and retires obstacles that leave the screen. It also counts retired obstacles as the score. Its behaviour follows the `gamemode` code that the game-logic stage drives back to it.

## Interface
- `SCREEN_W`, 640: x coordinate at which a new obstacle's left edge spawns.
- `OBS_W`, 40: obstacle width; new obstacles get x_right = SCREEN_W+OBS_W-1.
- `SPEED`, 4: pixels moved left per running cycle (≥1).
- `SPAWN_INTERVAL`, 60: running cycles between spawn attempts (≥1).
- `UPPER_BOUND`, 120: ceiling y.
- `LOWER_BOUND`, 360: floor y.
- `MIN_H`, 40: minimum obstacle height (≥1).
- `MAX_H`, 120: maximum obstacle height (≥MIN_H).
- `LFSR_SEED`, 16'hACE1: LFSR reset value (nonzero).
- `clk`, input, 1: clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `gamemode`, input, 2: 00 = initial, 01 = running, 10 = paused, 11 = ended.
- `obstacle_x`, output, 200: per slot k, `[k*20 +:10]` is x_left and `[k*20+10 +:10]` is x_right.
- `obstacle_y`, output, 180: per slot k, `[k*18 +:9]` is y_top and `[k*18+9 +:9]` is y_bottom.
- `score`, output, 16: number of obstacles retired since the last initial state; saturates at 16'hFFFF.

## Operation
- **Slot encoding**
  - A slot is free when all four of its fields are 0.
  - An active slot always has y_top ≠ y_bottom.
  - All outputs are registered directly from the slot registers.
- **LFSR**
  - 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1, shifting left.
  - new bit = l[15]^l[13]^l[12]^l[10].
  - Advances every clk in every mode.
  - A spawn uses the value held before that edge.
- **Spawn geometry**
  - Height h = MIN_H + (l[6:0] mod (MAX_H-MIN_H+1)).
  - If l[15]=0 the obstacle is ceiling-attached: y_top = UPPER_BOUND, y_bottom = UPPER_BOUND+h.
  - If l[15]=1 the obstacle is floor-attached: y_top = LOWER_BOUND-h, y_bottom = LOWER_BOUND.
  - x_left = SCREEN_W, x_right = SCREEN_W+OBS_W-1.
- **Mode 00 (initial)**
  - All slots cleared, spawn counter cleared, score cleared.
- **Mode 01 (running), each cycle**
  - Move: each active slot takes x_left ← max(x_left-SPEED, 0) and x_right ← x_right-SPEED.
  - Retire: an active slot with x_right < SPEED is cleared instead of moved, and score increments.
  - Several slots may retire in the same cycle; score adds the retire count, saturating.
  - Spawn counter: increments each cycle. When it equals SPAWN_INTERVAL-1 it wraps to 0 and a spawn attempt occurs.
  - Spawn target: the lowest-index slot that was free at the start of the cycle.
  - A slot retiring this cycle is not eligible until the next cycle.
  - With no free slot the spawn is dropped, the counter still wraps, and nothing is queued.
  - A spawned obstacle appears at the spawn position, unmoved, in this cycle.
- **Modes 10 and 11**
  - Slots, counter and score hold; obstacles stay visible.
  - A later return to 01 resumes with the counter where it stopped.
- **Mode transitions**
  - Leaving 11 for 00 clears everything on the first cycle gamemode reads 00.
  - Unknown or illegal mode values do not exist, since all 4 codes are defined.

## Timing
- **Reset values** (async, immediate): all obstacle_x/obstacle_y bits 0, score 0, spawn counter 0, LFSR = LFSR_SEED.
- **Sampling:** gamemode is sampled at each rising edge; effects are visible after that edge with 1-cycle latency.
- **First spawn:** occurs after the SPAWN_INTERVAL-th consecutive rising edge with gamemode=01 following the initial state.
- **Lifetime** with defaults: spawn x_right = 679. Each move subtracts 4, so x_right = 3 after 169 moves. The obstacle retires on the 170th running edge after spawning.
- **Reset mid-run:** returns to the reset values immediately; the LFSR restarts from the seed.
- **Simultaneity:** in one cycle, a retire in slot j and a spawn into a lower free slot i both take effect; a spawn never lands in j.

## Test plan
- **Reset and initial state:** assert rst_n=0 mid-run → all 380 obstacle bits 0, score 0; hold gamemode=00 for 100 cycles → outputs stay 0.
- **First spawn, defaults:** from reset, hold gamemode=01 → slot 0 becomes active on the 60th edge. x_left=640, x_right=679. y values match the reference LFSR model (seed ACE1 advanced 59 steps). Slots 1-9 stay 0.
- **Scroll and retire:** continue running → slot 0 x_left=636 after 1 edge. Slot 0 clears on the 170th edge after spawn, score=1. Slot 0 is reused by a later spawn.
- **Pause and end freeze:** run to 100 cycles, then hold gamemode=10 for 50 cycles → outputs unchanged. Return to 01 → the next spawn occurs 20 running cycles later. Hold 11 → frozen. Then 00 → all clear, score 0.
- **Full slots:** SPAWN_INTERVAL=2, SPEED=1 → slots 0-9 fill by edge 20, the 11th spawn is dropped. Slot 0 retires at 680 running edges after its spawn, score=1, and slot 0 refills on the next spawn attempt only.
- **Geometry bounds:** run 10000 cycles with defaults → every active slot satisfies one of:
  - y_top=120 with y_bottom in 160..240;
  - y_bottom=360 with y_top in 240..320.

  Also every active slot has x_right-x_left ≤ 39 and y_top ≠ y_bottom.
